data_req_gen: RTL
=================

# data_req_gen

Self-sequencing read-address generator for the input feature-map block RAM. It is the parametrised successor of the fixed 3-row / 3-channel request block. From a single start pulse it walks every kernel-row line of every output-row window. Kernel size, stride, channel count and base address are configurable, and line length is computed internally. It sits between the layer controller (start/abort/config) and the data BRAM read port, and is back-pressured by the PE array stall.

## Interface
Parameters:
- ADDR_WIDTH, 32, BRAM word-address width
- KERNEL_SIZE_WIDTH, 3, width of kernel-size field (K ≤ 2^KERNEL_SIZE_WIDTH−1)
- REG_WIDTH, 32, config/debug register width
- WORD_BYTES_LOG2, 2, log2 of bytes per BRAM word
- DIM_WIDTH, 8, width of width/height/channel fields

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; starts a layer traversal when idle
- i_abort  in  1  stops traversal; no o_done
- i_stall  in  1  suppresses o_rden and freezes all counters
- i_conf_inputshape  in  REG_WIDTH  [7:0] width W, [15:8] height H, [23:16] channels C
- i_conf_kernelshape  in  REG_WIDTH  [KERNEL_SIZE_WIDTH-1:0] K, [11:8] stride S
- i_conf_baseaddr  in  ADDR_WIDTH  word address of pixel (0,0)
- o_addr  out  ADDR_WIDTH  read address
- o_rden  out  1  read enable
- o_line_last  out  1  qualifies the last word of a kernel-row line
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse after the final read
- o_err  out  1  one-cycle pulse on illegal config
- dbg_datareq_knlinex_cnt  out  REG_WIDTH  zero-extended ky counter
- dbg_datareq_addr_reg  out  REG_WIDTH  o_addr, truncated or zero-extended

## Operation
- States:
  - IDLE: i_start → PREP.
  - PREP: one cycle; latches config and computes LW and SW.
    - Illegal config → o_err pulse, back to IDLE.
    - Otherwise → RUN.
  - RUN: issues reads. Final read → DONE. i_abort → IDLE.
  - DONE: one cycle; o_done=1, then → IDLE.
- PREP arithmetic (all unsigned):
  - LW = ceil(W·C / 2^WORD_BYTES_LOG2), 16-bit result.
  - SW = S·LW, 20 bits.
- Illegal config: any of K=0, S=0, W=0, C=0, K>H.
- Counters:
  - col: 0..LW−1
  - ky: 0..K−1
  - oy: output-row origin
  - win_base: address of row oy; reset to i_conf_baseaddr in PREP
  - line_base: address of row oy+ky
- o_addr = line_base + col.
- On each o_rden cycle:
  - col < LW−1: col++.
  - Otherwise o_line_last=1, col=0, and:
    - ky < K−1: ky++, line_base += LW.
    - ky = K−1: ky=0, oy += S, win_base += SW, line_base = new win_base.
  - If that was the last line of the window and oy+S+K > H, the read is final → DONE.
- Windows are therefore oy = 0, S, 2S, … while oy+K ≤ H.
- Address adds wrap modulo 2^ADDR_WIDTH.
- i_start in any state other than IDLE is ignored.
- i_abort outside RUN is ignored. i_abort has priority over i_stall and over the final read.
- Config inputs are sampled only in PREP; later changes have no effect on the running traversal.

## Timing
- Reset values: o_addr=0, o_rden=0, o_line_last=0, o_busy=0, o_done=0, o_err=0, both dbg outputs=0, state=IDLE. All counters are 0.
- rst mid-traversal → IDLE next cycle, no o_done.
- o_rden = (state==RUN) & ~i_stall & ~i_abort, combinational.
- o_addr and o_line_last are valid whenever o_rden=1. o_addr is held during stall.
- Latency: i_start at cycle 0 → PREP at cycle 1 → first o_rden at cycle 2 (no stall).
- o_done is asserted the cycle after the final o_rden.
- o_err is asserted the cycle after PREP evaluation (cycle 2).
- Throughput: one read per unstalled cycle, no bubbles between lines or windows.
- Total reads = LW · K · floor((H−K)/S + 1).

## Structure
- Shared package holds:
  - state encoding (IDLE/PREP/RUN/DONE)
  - config field offsets for inputshape and kernelshape
  - the WORD_BYTES_LOG2 default
- One natural sub-module: data_req_linecalc. Combinational/registered LW and SW computation, reusable by the weight request path.
- Everything else lives in one file.

## Test plan
- W=8, H=4, C=3, K=3, S=1, base=0x100 → LW=6. Reads 0x100..0x111, then 0x106..0x117 (36 reads). o_line_last on every 6th read. o_done at cycle 38.
- W=5, C=3 → LW=4 (15 bytes rounded up). With K=1, S=1, H=2 → 8 reads, 0x0..0x7.
- W=4, H=5, C=4, K=3, S=2 → LW=4. Windows at oy=0,2; second window starts at base+8. Total 24 reads.
- i_stall held 3 cycles mid-line → o_rden=0 and o_addr frozen for 3 cycles. The sequence resumes unchanged and o_done is delayed by exactly 3 cycles.
- K=0, and separately K=4 with H=3 → o_err at cycle 2, no o_rden, o_busy low at cycle 3.
- i_abort after 5 reads → o_rden low that cycle, IDLE next cycle, no o_done. A new i_start restarts from base.

Source files
------------

// File: rtl/data_req_gen_pkg.sv
// data_req_gen_pkg: shared state encoding, config field offsets and defaults
package data_req_gen_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_RUN, ST_DONE} state_t;
    localparam int WORD_BYTES_LOG2_DEF = 2;
    localparam int IS_W_LSB = 0;
    localparam int IS_H_LSB = 8;
    localparam int IS_C_LSB = 16;
    localparam int KS_K_LSB = 0;
    localparam int KS_S_LSB = 8;
    localparam int KS_S_WIDTH = 4;
    localparam int LW_WIDTH = 16;
    localparam int SW_WIDTH = 20;
endpackage

// File: rtl/data_req_gen_if.sv
// data_req_gen_if: data BRAM read-request port with PE-array stall
interface data_req_gen_if #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rden;
    logic                  line_last;
    logic                  stall;
    modport master (output addr, rden, line_last, input stall);
    modport slave  (input addr, rden, line_last, output stall);
endinterface

// File: rtl/data_req_gen_linecalc.sv
// data_req_linecalc: words per feature-map row (LW) and words per stride step (SW)
module data_req_linecalc import data_req_gen_pkg::*; #(
    parameter int DIM_WIDTH       = 8,
    parameter int WORD_BYTES_LOG2 = WORD_BYTES_LOG2_DEF
) (
    input  logic [DIM_WIDTH-1:0]  w_i,
    input  logic [DIM_WIDTH-1:0]  c_i,
    input  logic [KS_S_WIDTH-1:0] s_i,
    output logic [LW_WIDTH-1:0]   lw_o,
    output logic [SW_WIDTH-1:0]   sw_o
);
    localparam int PW = 2 * DIM_WIDTH + 1;
    localparam logic [PW-1:0] RND = PW'((1 << WORD_BYTES_LOG2) - 1);
    logic [PW-1:0] bytes_w;
    assign bytes_w = PW'(w_i) * PW'(c_i) + RND;
    assign lw_o    = LW_WIDTH'(bytes_w >> WORD_BYTES_LOG2);
    assign sw_o    = SW_WIDTH'(s_i) * SW_WIDTH'(lw_o);
endmodule

// File: rtl/data_req_gen.sv
// data_req_gen: walks every kernel-row line of every output-row window of the input feature map
module data_req_gen import data_req_gen_pkg::*; #(
    parameter int ADDR_WIDTH        = 32,
    parameter int KERNEL_SIZE_WIDTH = 3,
    parameter int REG_WIDTH         = 32,
    parameter int WORD_BYTES_LOG2   = WORD_BYTES_LOG2_DEF,
    parameter int DIM_WIDTH         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
    input  logic [ADDR_WIDTH-1:0] i_conf_baseaddr,
    data_req_gen_if.master        rd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  dbg_datareq_knlinex_cnt,
    output logic [REG_WIDTH-1:0]  dbg_datareq_addr_reg
);
    localparam int KW = KERNEL_SIZE_WIDTH;
    localparam int CW = DIM_WIDTH + 2;
    state_t                state_q;
    logic                  err_q;
    logic [DIM_WIDTH-1:0]  h_q, oy_q;
    logic [KW-1:0]         k_q, ky_q;
    logic [KS_S_WIDTH-1:0] s_q;
    logic [LW_WIDTH-1:0]   lw_q, col_q;
    logic [SW_WIDTH-1:0]   sw_q;
    logic [ADDR_WIDTH-1:0] win_base_q, line_base_q, win_base_d, addr;
    logic [DIM_WIDTH-1:0]  w_cfg, h_cfg, c_cfg;
    logic [KW-1:0]         k_cfg;
    logic [KS_S_WIDTH-1:0] s_cfg;
    logic [LW_WIDTH-1:0]   lw_cfg;
    logic [SW_WIDTH-1:0]   sw_cfg;
    logic                  illegal, rden, line_end, win_end, final_rd, unused_cfg;
    assign w_cfg = i_conf_inputshape[IS_W_LSB +: DIM_WIDTH];
    assign h_cfg = i_conf_inputshape[IS_H_LSB +: DIM_WIDTH];
    assign c_cfg = i_conf_inputshape[IS_C_LSB +: DIM_WIDTH];
    assign k_cfg = i_conf_kernelshape[KS_K_LSB +: KW];
    assign s_cfg = i_conf_kernelshape[KS_S_LSB +: KS_S_WIDTH];
    assign unused_cfg = ^{i_conf_inputshape, i_conf_kernelshape};
    assign illegal = k_cfg == '0 || s_cfg == '0 || w_cfg == '0 || c_cfg == '0 || CW'(k_cfg) > CW'(h_cfg);
    data_req_linecalc #(.DIM_WIDTH(DIM_WIDTH), .WORD_BYTES_LOG2(WORD_BYTES_LOG2)) u_linecalc (
        .w_i  (w_cfg),
        .c_i  (c_cfg),
        .s_i  (s_cfg),
        .lw_o (lw_cfg),
        .sw_o (sw_cfg)
    );
    assign rden       = state_q == ST_RUN && !rd.stall && !i_abort;
    assign line_end   = col_q == lw_q - LW_WIDTH'(1);
    assign win_end    = line_end && ky_q == k_q - KW'(1);
    assign final_rd   = win_end && CW'(oy_q) + CW'(s_q) + CW'(k_q) > CW'(h_q);
    assign win_base_d = win_base_q + ADDR_WIDTH'(sw_q);
    assign addr       = line_base_q + ADDR_WIDTH'(col_q);
    assign rd.addr      = addr;
    assign rd.rden      = rden;
    assign rd.line_last = rden && line_end;
    assign o_busy = state_q != ST_IDLE;
    assign o_done = state_q == ST_DONE;
    assign o_err  = err_q;
    assign dbg_datareq_knlinex_cnt = REG_WIDTH'(ky_q);
    assign dbg_datareq_addr_reg    = REG_WIDTH'(addr);
    // Sequencer: config latch in PREP, then col/ky/window counters advance on every issued read
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            h_q         <= '0;
            k_q         <= '0;
            s_q         <= '0;
            lw_q        <= '0;
            sw_q        <= '0;
            col_q       <= '0;
            ky_q        <= '0;
            oy_q        <= '0;
            win_base_q  <= '0;
            line_base_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= i_start ? ST_PREP : ST_IDLE;
                ST_PREP: begin
                    h_q         <= h_cfg;
                    k_q         <= k_cfg;
                    s_q         <= s_cfg;
                    lw_q        <= lw_cfg;
                    sw_q        <= sw_cfg;
                    col_q       <= '0;
                    ky_q        <= '0;
                    oy_q        <= '0;
                    win_base_q  <= i_conf_baseaddr;
                    line_base_q <= i_conf_baseaddr;
                    err_q       <= illegal;
                    state_q     <= illegal ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                    end else if (rden) begin
                        if (!line_end) begin
                            col_q <= col_q + LW_WIDTH'(1);
                        end else begin
                            col_q <= '0;
                            if (!win_end) begin
                                ky_q        <= ky_q + KW'(1);
                                line_base_q <= line_base_q + ADDR_WIDTH'(lw_q);
                            end else begin
                                ky_q        <= '0;
                                oy_q        <= oy_q + DIM_WIDTH'(s_q);
                                win_base_q  <= win_base_d;
                                line_base_q <= win_base_d;
                            end
                        end
                        state_q <= final_rd ? ST_DONE : ST_RUN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
